// File: rtl/fifo_sync_ctrl_pkg.sv
// Shared constants for the synchronous FIFO pointer/flag controller.
// Provides default depth/thresholds and the pointer-width rule.
package fifo_sync_ctrl_pkg;

    localparam int DEF_DEPTH     = 16;
    localparam int DEF_AF_THRESH = 12;
    localparam int DEF_AE_THRESH = 4;

    // Pointer carries one extra wrap bit above the memory index.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int DEF_PTR_WIDTH = ptr_width(DEF_DEPTH);

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit binary pointer with synchronous reset/clear and increment.
// Ports: clk, rst_i (sync, high), clr_i (sync flush), inc_i, ptr_o.
module fifo_ptr #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] ptr_o
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_sync_ctrl.sv
// Pointer/flag controller for a synchronous FIFO: qualifies push/pop,
// advances wrap-bit pointers, reports count, threshold and sticky errors.
// Ports: clk, rst_in, clear_in, write_in, read_in -> write_ptr_out,
//   read_ptr_out, full_out, empty_out, almost_full_out,
//   almost_empty_out, count_out, overflow_out, underflow_out.
module fifo_sync_ctrl
    import fifo_sync_ctrl_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int PTR_WIDTH = ptr_width(DEPTH),
    parameter int AF_THRESH = DEF_AF_THRESH,
    parameter int AE_THRESH = DEF_AE_THRESH
) (
    input  logic                 clk,
    input  logic                 rst_in,
    input  logic                 clear_in,
    input  logic                 write_in,
    input  logic                 read_in,
    output logic [PTR_WIDTH-1:0] write_ptr_out,
    output logic [PTR_WIDTH-1:0] read_ptr_out,
    output logic                 full_out,
    output logic                 empty_out,
    output logic                 almost_full_out,
    output logic                 almost_empty_out,
    output logic [PTR_WIDTH-1:0] count_out,
    output logic                 overflow_out,
    output logic                 underflow_out
);

    localparam int MSB = PTR_WIDTH - 1;
    localparam logic [PTR_WIDTH-1:0] AF_T = PTR_WIDTH'(AF_THRESH);
    localparam logic [PTR_WIDTH-1:0] AE_T = PTR_WIDTH'(AE_THRESH);

    logic wr_ok;
    logic rd_ok;
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    // Flags depend only on registered pointers, so qualification
    // never creates a path from the request inputs to an output.
    assign wr_ok = write_in & ~full_out;
    assign rd_ok = read_in & ~empty_out;

    fifo_ptr #(.W(PTR_WIDTH)) u_wptr (
        .clk   (clk),
        .rst_i (rst_in),
        .clr_i (clear_in),
        .inc_i (wr_ok),
        .ptr_o (write_ptr_out)
    );

    fifo_ptr #(.W(PTR_WIDTH)) u_rptr (
        .clk   (clk),
        .rst_i (rst_in),
        .clr_i (clear_in),
        .inc_i (rd_ok),
        .ptr_o (read_ptr_out)
    );

    assign empty_out = (write_ptr_out == read_ptr_out);
    assign full_out  = (write_ptr_out[MSB] != read_ptr_out[MSB])
                    && (write_ptr_out[MSB-1:0] == read_ptr_out[MSB-1:0]);
    assign count_out = write_ptr_out - read_ptr_out;

    assign almost_full_out  = (count_out >= AF_T);
    assign almost_empty_out = (count_out <= AE_T);

    // A flush overrides the request, so it cannot raise an error;
    // existing errors survive the flush.
    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (!clear_in) begin
            ovf_d = ovf_q | (write_in & full_out);
            unf_d = unf_q | (read_in & empty_out);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign overflow_out  = ovf_q;
    assign underflow_out = unf_q;

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Self-checking bench for fifo_sync_ctrl (DEPTH=16, AF=12, AE=4).
// Occupancy model plus directed vectors with literal expectations.
module tb_fifo_sync_ctrl;

    localparam int D  = 16;
    localparam int PW = 5;

    logic          clk = 1'b0;
    logic          rst_in = 1'b0;
    logic          clear_in = 1'b0;
    logic          write_in = 1'b0;
    logic          read_in = 1'b0;
    logic [PW-1:0] write_ptr_out;
    logic [PW-1:0] read_ptr_out;
    logic          full_out;
    logic          empty_out;
    logic          almost_full_out;
    logic          almost_empty_out;
    logic [PW-1:0] count_out;
    logic          overflow_out;
    logic          underflow_out;

    int vectors = 0;
    int miscompares = 0;

    fifo_sync_ctrl #(
        .DEPTH     (16),
        .PTR_WIDTH (5),
        .AF_THRESH (12),
        .AE_THRESH (4)
    ) dut (
        .clk              (clk),
        .rst_in           (rst_in),
        .clear_in         (clear_in),
        .write_in         (write_in),
        .read_in          (read_in),
        .write_ptr_out    (write_ptr_out),
        .read_ptr_out     (read_ptr_out),
        .full_out         (full_out),
        .empty_out        (empty_out),
        .almost_full_out  (almost_full_out),
        .almost_empty_out (almost_empty_out),
        .count_out        (count_out),
        .overflow_out     (overflow_out),
        .underflow_out    (underflow_out)
    );

    always #5 clk = ~clk;

    // Model: occupancy and push/pop totals, pointers derived modulo 32.
    int  m_cnt = 0;
    int  m_pushes = 0;
    int  m_pops = 0;
    bit  m_ovf = 0;
    bit  m_unf = 0;
    bit  m_valid = 0;

    always @(posedge clk) begin
        if (rst_in) begin
            m_cnt    <= 0;
            m_pushes <= 0;
            m_pops   <= 0;
            m_ovf    <= 0;
            m_unf    <= 0;
            m_valid  <= 1;
        end else if (clear_in) begin
            m_cnt    <= 0;
            m_pushes <= 0;
            m_pops   <= 0;
        end else begin
            bit wok, rok;
            wok = write_in && (m_cnt < D);
            rok = read_in && (m_cnt > 0);
            m_cnt    <= m_cnt + int'(wok) - int'(rok);
            m_pushes <= m_pushes + int'(wok);
            m_pops   <= m_pops + int'(rok);
            if (write_in && m_cnt == D) m_ovf <= 1;
            if (read_in && m_cnt == 0) m_unf <= 1;
        end
    end

    // Every-cycle comparison on the falling edge.
    always @(negedge clk) begin
        if (m_valid) begin
            int ew, er;
            bit ef, ee, eaf, eae;
            ew  = m_pushes % 32;
            er  = m_pops % 32;
            ef  = (m_cnt == D);
            ee  = (m_cnt == 0);
            eaf = (m_cnt >= 12);
            eae = (m_cnt <= 4);
            vectors++;
            if (int'(write_ptr_out) != ew || int'(read_ptr_out) != er ||
                int'(count_out) != m_cnt || full_out != ef ||
                empty_out != ee || almost_full_out != eaf ||
                almost_empty_out != eae || overflow_out != m_ovf ||
                underflow_out != m_unf) begin
                miscompares++;
                $display("FAIL model t=%0t got w=%0d r=%0d c=%0d f%0b e%0b af%0b ae%0b o%0b u%0b exp w=%0d r=%0d c=%0d f%0b e%0b af%0b ae%0b o%0b u%0b",
                    $time, write_ptr_out, read_ptr_out, count_out,
                    full_out, empty_out, almost_full_out,
                    almost_empty_out, overflow_out, underflow_out,
                    ew, er, m_cnt, ef, ee, eaf, eae, m_ovf, m_unf);
            end
        end
    end

    task automatic step(input bit w, input bit r,
                        input bit c, input bit rs);
        write_in = w;
        read_in  = r;
        clear_in = c;
        rst_in   = rs;
        @(posedge clk);
        #1;
        write_in = 0;
        read_in  = 0;
        clear_in = 0;
        rst_in   = 0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag, input int unf);
        chk({tag, "_wptr"}, int'(write_ptr_out), 0);
        chk({tag, "_rptr"}, int'(read_ptr_out), 0);
        chk({tag, "_count"}, int'(count_out), 0);
        chk({tag, "_empty"}, int'(empty_out), 1);
        chk({tag, "_full"}, int'(full_out), 0);
        chk({tag, "_ae"}, int'(almost_empty_out), 1);
        chk({tag, "_af"}, int'(almost_full_out), 0);
        chk({tag, "_ovf"}, int'(overflow_out), 0);
        chk({tag, "_unf"}, int'(underflow_out), unf);
    endtask

    initial begin
        @(posedge clk);
        #1;
        // 1. reset
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk_reset_vals("rst", 0);

        // 2. fill to full, then overflow
        for (int i = 0; i < 16; i++) step(1, 0, 0, 0);
        chk("fill_full", int'(full_out), 1);
        chk("fill_wptr", int'(write_ptr_out), 16);
        chk("fill_count", int'(count_out), 16);
        chk("fill_af", int'(almost_full_out), 1);
        step(1, 0, 0, 0);
        chk("ovf_wptr", int'(write_ptr_out), 16);
        chk("ovf_flag", int'(overflow_out), 1);

        // 3. simultaneous push/pop at count 5 and at full
        step(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        chk("wr5_count", int'(count_out), 5);
        chk("wr5_wptr", int'(write_ptr_out), 6);
        chk("wr5_rptr", int'(read_ptr_out), 1);
        for (int i = 0; i < 11; i++) step(1, 0, 0, 0);
        chk("wrf_full", int'(full_out), 1);
        step(1, 1, 0, 0);
        chk("wrf_count", int'(count_out), 15);
        chk("wrf_wptr", int'(write_ptr_out), 17);
        chk("wrf_rptr", int'(read_ptr_out), 2);
        chk("wrf_full_drop", int'(full_out), 0);

        // 4. 20 write/read pairs with wrap-around
        step(0, 0, 0, 1);
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 0, 0);
            step(0, 1, 0, 0);
            chk("pair_empty", int'(empty_out), 1);
            chk("pair_count", int'(count_out), 0);
        end
        chk("pair_wptr", int'(write_ptr_out), 5'b10100);
        chk("pair_rptr", int'(read_ptr_out), 5'b10100);

        // 5. underflow, push+pop on empty, clear keeps sticky error
        step(0, 1, 0, 0);
        chk("unf_rptr", int'(read_ptr_out), 20);
        chk("unf_flag", int'(underflow_out), 1);
        step(1, 1, 0, 0);
        chk("we_count", int'(count_out), 1);
        chk("we_rptr", int'(read_ptr_out), 20);
        step(0, 0, 1, 0);
        chk_reset_vals("clr", 1);

        // 6. reset mid-operation, then almost_empty boundary
        for (int i = 0; i < 9; i++) step(1, 0, 0, 0);
        chk("mid_count", int'(count_out), 9);
        step(0, 0, 0, 1);
        chk_reset_vals("mid_rst", 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
        chk("ae_at4", int'(almost_empty_out), 1);
        step(1, 0, 0, 0);
        chk("ae_at5", int'(almost_empty_out), 0);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
